// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the single-clock FIFO family.
package fifo_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 16;

  // Read-port modes selected by the FWFT parameter.
  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // One extra bit so that a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Request/response bundle between a FIFO (slave) and the block driving it (master).
interface sync_fifo_param_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);

  localparam int CNT_W = cnt_w(DEPTH);

  logic              clr;
  logic              wr;
  logic [DATA_W-1:0] wdata;
  logic              rd;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output clr, wr, wdata, rd,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  clr, wr, wdata, rd,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W flop RAM: synchronous write port, asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    i_we,
  input  logic [ptr_w(DEPTH)-1:0] i_waddr,
  input  logic [DATA_W-1:0]       i_wdata,
  input  logic [ptr_w(DEPTH)-1:0] i_raddr,
  output logic [DATA_W-1:0]       o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // NOTE: the storage array is deliberately not reset; validity is tracked by the
  // pointers and count, and leaving it out keeps the array as plain enable flops.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parametrised FIFO with occupancy count, threshold flags, optional
// first-word-fall-through read port, synchronous flush and sticky error flags.
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AFULL_TH  = DEPTH - 2,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = FWFT_STD
) (
  input  logic              clk,
  input  logic              rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_TH);
  localparam logic [CNT_W-1:0] CNT_AEMP  = CNT_W'(AEMPTY_TH);

  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_overflow;
  logic              r_underflow;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_ok;
  logic              w_rd_ok;
  logic              w_mem_we;
  logic [DATA_W-1:0] w_mem_rdata;

  // Flags decode the registered count, so they describe the state after the last edge.
  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);

  assign w_wr_ok  = bus.wr && !w_full;
  assign w_rd_ok  = bus.rd && !w_empty;
  assign w_mem_we = rst_n && !bus.clr && w_wr_ok;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_waddr (r_wptr),
    .i_wdata (bus.wdata),
    .i_raddr (r_rptr),
    .o_rdata (w_mem_rdata)
  );

  // NOTE: all state below uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
    end else if (bus.clr) begin
      // Flush drops both requests; memory and the last rdata are left untouched.
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rvalid    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_ok) begin
        r_rptr  <= r_rptr + PTR_ONE;
        r_rdata <= w_mem_rdata;
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CNT_ONE;
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - CNT_ONE;
      end
      if (bus.wr && w_full) begin
        r_overflow <= 1'b1;
      end
      if (bus.rd && w_empty) begin
        r_underflow <= 1'b1;
      end
      r_rvalid <= w_rd_ok;
    end
  end

  // FWFT exposes the head entry directly; standard mode presents the registered pop.
  assign bus.rdata        = (FWFT == FWFT_ON) ? w_mem_rdata : r_rdata;
  assign bus.rvalid       = (FWFT == FWFT_ON) ? !w_empty    : r_rvalid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.almost_full  = (r_count >= CNT_AFULL);
  assign bus.almost_empty = (r_count <= CNT_AEMP);
  assign bus.count        = r_count;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
